clock_gate_controller: RTL

- Sequences the glitchless clock gate that feeds the compute array, driving the gate's active-low enable.
- Starts a run on host command and stops the gated clock on a cycle budget, an execution-done flag or any halt request, then reports a settled "stopped" status.
- Sits in the always-on clock domain (`clock`) between the host control registers and the clock buffer cell.
- Resumes after halts without losing the executed-cycle count.

---
 rtl/clock_gate_controller_pkg.sv | 33 +++
 rtl/clock_gate_settle_counter.sv | 33 +++
 rtl/clock_gate_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/clock_gate_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : clock_gate_controller_pkg                                       |
// | Brief  : Shared states, stop-cause codes and default widths.             |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
package clock_gate_controller_pkg;

  localparam int c_default_budget_w = 48;
  localparam int c_default_n_halt   = 4;
  localparam int c_default_settle   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    STOPPED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BUDGET = 2'd1,
    CAUSE_HALT   = 2'd2,
    CAUSE_DONE   = 2'd3
  } cause_t;

  // A settle count of 1 still needs a 1-bit counter.
  function automatic int settle_cnt_w(input int settle);
    return (settle > 1) ? $clog2(settle) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_gate_settle_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : clock_gate_settle_counter                                       |
// | Brief  : Loadable down-counter with zero flag, paces the DRAIN state.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module clock_gate_settle_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/clock_gate_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : clock_gate_controller                                           |
// | Brief  : Run/stop sequencer for the compute-array glitchless clock gate. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module clock_gate_controller
  import clock_gate_controller_pkg::*;
#(
  parameter int BUDGET_W = c_default_budget_w,
  parameter int N_HALT   = c_default_n_halt,
  parameter int SETTLE   = c_default_settle
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BUDGET_W-1:0] budget,
  input  logic [N_HALT-1:0]   halt_req,
  input  logic                resume,
  input  logic                done,
  output logic                gate_n,
  output logic                running,
  output logic                stopped,
  output logic [1:0]          cause,
  output logic [N_HALT-1:0]   halt_src,
  output logic [BUDGET_W-1:0] cycles
);

  localparam int                 c_cnt_w       = settle_cnt_w(SETTLE);
  localparam logic [c_cnt_w-1:0] c_settle_init = c_cnt_w'(SETTLE - 1);

  state_t              r_state;
  logic                r_gate_n;
  logic                r_running;
  logic                r_stopped;
  cause_t              r_cause;
  logic [N_HALT-1:0]   r_halt_src;
  logic [BUDGET_W-1:0] r_cycles;
  logic [BUDGET_W-1:0] r_budget;

  logic [BUDGET_W-1:0] w_cycles_inc;
  cause_t              w_stop_cause;
  logic                w_stop;
  logic                w_resume_ok;
  logic                w_settle_load;
  logic                w_settle_dec;
  logic                w_settle_zero;

  always_comb begin
    w_cycles_inc = r_cycles + 1'b1;

    w_stop_cause = CAUSE_NONE;
    if (|halt_req) begin
      w_stop_cause = CAUSE_HALT;
    end else if (done) begin
      w_stop_cause = CAUSE_DONE;
    end else if ((r_budget != '0) && (w_cycles_inc == r_budget)) begin
      w_stop_cause = CAUSE_BUDGET;
    end
    w_stop = (r_state == RUN) && (w_stop_cause != CAUSE_NONE);

    // The budget is an absolute total, so a resume must leave headroom.
    w_resume_ok = 1'b0;
    if ((r_state == STOPPED) && resume && !start) begin
      case (r_cause)
        CAUSE_HALT:   w_resume_ok = (halt_req == '0);
        CAUSE_BUDGET: w_resume_ok = (budget == '0) || (budget > r_cycles);
        default:      w_resume_ok = 1'b0;
      endcase
    end

    w_settle_load = w_stop;
    w_settle_dec  = (r_state == DRAIN) && !w_settle_zero;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_gate_n   <= 1'b1;
      r_running  <= 1'b0;
      r_stopped  <= 1'b1;
      r_cause    <= CAUSE_NONE;
      r_halt_src <= '0;
      r_cycles   <= '0;
      r_budget   <= '0;
    end else begin
      case (r_state)
        IDLE, STOPPED: begin
          if (start) begin
            r_budget   <= budget;
            r_cycles   <= '0;
            r_cause    <= CAUSE_NONE;
            r_halt_src <= '0;
            r_gate_n   <= 1'b0;
            r_running  <= 1'b1;
            r_stopped  <= 1'b0;
            r_state    <= RUN;
          end else if (w_resume_ok) begin
            if (r_cause == CAUSE_BUDGET) begin
              r_budget <= budget;
            end
            r_gate_n  <= 1'b0;
            r_running <= 1'b1;
            r_stopped <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          // The stopping edge is still an ungated edge and counts.
          r_cycles <= w_cycles_inc;
          if (w_stop) begin
            r_gate_n   <= 1'b1;
            r_running  <= 1'b0;
            r_cause    <= w_stop_cause;
            r_halt_src <= (w_stop_cause == CAUSE_HALT) ? halt_req : '0;
            r_state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_settle_zero) begin
            r_stopped <= 1'b1;
            r_state   <= STOPPED;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  clock_gate_settle_counter #(
    .WIDTH (c_cnt_w)
  ) u_settle (
    .clock    (clock),
    .reset    (reset),
    .load     (w_settle_load),
    .load_val (c_settle_init),
    .dec      (w_settle_dec),
    .zero     (w_settle_zero)
  );

  assign gate_n   = r_gate_n;
  assign running  = r_running;
  assign stopped  = r_stopped;
  assign cause    = r_cause;
  assign halt_src = r_halt_src;
  assign cycles   = r_cycles;

endmodule
`default_nettype wire
